// File: rtl/hub75_probe_capture.sv
// Circular-buffer logic analyser for the HUB75 driver probes.
// Captures pre-trigger history, waits for a mask/value trigger, fills the rest, then serves chronological reads.
module hub75_probe_capture #(
    parameter int DATA_W     = 12,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     probe_i,
    input  logic                  arm_i,
    input  logic                  abort_i,
    input  logic [DATA_W-1:0]     trig_mask_i,
    input  logic [DATA_W-1:0]     trig_value_i,
    input  logic                  trig_edge_i,
    input  logic [DEPTH_LOG2-1:0] pretrig_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2-1:0] rd_addr_i,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_valid_o,
    output logic [2:0]            state_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2-1:0] trig_addr_o
);

    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] IDX_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [DEPTH_LOG2-1:0] r_wrPtr;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DEPTH_LOG2-1:0] r_pretrig;
    logic [DEPTH_LOG2-1:0] r_startPtr;
    logic                  r_lvlQ;
    logic [DATA_W-1:0]     r_ram [DEPTH];
    logic [DATA_W-1:0]     r_rdData;
    logic                  r_rdValid;

    logic                  w_lvl;
    logic                  w_hit;
    logic                  w_start;
    logic                  w_write;
    logic                  w_rdOk;
    logic [DEPTH_LOG2-1:0] w_rdPhys;

    // The port width already bounds pretrig to DEPTH-1, so the clamp is implicit.
    assign w_lvl    = ((probe_i ^ trig_value_i) & trig_mask_i) == '0;
    assign w_start  = arm_i && !abort_i && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_hit    = (r_state == ST_WAIT) && !abort_i &&
                      (trig_edge_i ? (w_lvl && !r_lvlQ) : w_lvl);
    assign w_write  = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    assign w_rdOk   = rd_en_i && (r_state == ST_DONE) && !abort_i;
    assign w_rdPhys = r_startPtr + rd_addr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (abort_i) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        w_nextState = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (r_cnt == r_pretrig - IDX_ONE) begin
                        w_nextState = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_hit) begin
                        w_nextState = (r_pretrig == IDX_MAX) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (r_cnt == IDX_ONE) begin
                        w_nextState = ST_DONE;
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    // lvl_q is held clear through PRE so a level already true at WAIT entry reads as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr    <= '0;
            r_cnt      <= '0;
            r_pretrig  <= '0;
            r_startPtr <= '0;
            r_lvlQ     <= 1'b0;
        end else if (w_start) begin
            r_pretrig <= pretrig_i;
            r_wrPtr   <= '0;
            r_cnt     <= '0;
            r_lvlQ    <= 1'b0;
        end else begin
            case (r_state)
                ST_PRE: begin
                    r_wrPtr <= r_wrPtr + IDX_ONE;
                    r_cnt   <= r_cnt + IDX_ONE;
                    r_lvlQ  <= 1'b0;
                end
                ST_WAIT: begin
                    r_wrPtr <= r_wrPtr + IDX_ONE;
                    r_lvlQ  <= w_lvl;
                    if (w_hit) begin
                        r_startPtr <= r_wrPtr - r_pretrig;
                        r_cnt      <= IDX_MAX - r_pretrig;
                    end
                end
                ST_POST: begin
                    r_wrPtr <= r_wrPtr + IDX_ONE;
                    r_cnt   <= r_cnt - IDX_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_ram[r_wrPtr] <= probe_i;
        end
    end

    // Read data only moves on an accepted read so the host sees a stable word otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
        end else begin
            r_rdValid <= w_rdOk;
            if (w_rdOk) begin
                r_rdData <= r_ram[w_rdPhys];
            end
        end
    end

    assign rd_data_o   = r_rdData;
    assign rd_valid_o  = r_rdValid;
    assign state_o     = r_state;
    assign done_o      = (r_state == ST_DONE);
    assign trig_addr_o = r_pretrig;

endmodule
